// File: rtl/clock_pkg.sv
// Shared types and limits for the 12-hour clock datapath.
// Wrap helpers keep edited values inside 0..max.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_e;

  localparam int HR_MAX_DEF  = 11;
  localparam int MIN_MAX_DEF = 59;

  function automatic logic [6:0] wrap_inc(
    input logic [6:0] v,
    input logic [6:0] max
  );
    return (v >= max) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] wrap_dec(
    input logic [6:0] v,
    input logic [6:0] max
  );
    return (v == 7'd0 || v > max) ? max : v - 7'd1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Button press detect with hold-to-repeat.
// step_o fires on press, after REPEAT_DLY cycles held, then every REPEAT_RATE+1.
module btn_repeat #(
  parameter int REPEAT_DLY  = 49999999,
  parameter int REPEAT_RATE = 9999999
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic clr_i,
  output logic lvl_o,
  output logic press_o,
  output logic step_o
);

  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ?
                        REPEAT_DLY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE);

  logic          lvl_q;
  logic          prv_q;
  logic          rep_q;
  logic [RW-1:0] cnt_q;
  logic          press;
  logic          hit;

  assign press = lvl_q & ~prv_q;
  assign hit   = rep_q ? (cnt_q == RATE_LAST)
                       : (cnt_q == DLY_LAST);

  assign lvl_o   = lvl_q;
  assign press_o = press;
  assign step_o  = ~clr_i & (press | (lvl_q & hit));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q <= 1'b0;
      prv_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      lvl_q <= btn_i;
      prv_q <= lvl_q;
      if (!lvl_q || clr_i || press) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else if (hit) begin
        cnt_q <= '0;
        rep_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + RW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: RUN -> SET_HR -> SET_MIN -> COMMIT.
// Holds the timebase while editing and blinks the edited field.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HR_MAX      = HR_MAX_DEF,
  parameter int MIN_MAX     = MIN_MAX_DEF,
  parameter int BLINK_DIV   = 24999999,
  parameter int REPEAT_DLY  = 49999999,
  parameter int REPEAT_RATE = 9999999,
  parameter int TIMEOUT     = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic       dec_btn_i,
  input  logic [6:0] hours_i,
  input  logic [6:0] minutes_i,
  output logic [6:0] set_hour_o,
  output logic [6:0] set_min_o,
  output logic       load_o,
  output logic       run_en_o,
  output logic       blank_hr_o,
  output logic       blank_min_o,
  output logic [1:0] state_o
);

  localparam int BW = $clog2(BLINK_DIV) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [6:0]    HMAX    = 7'(HR_MAX);
  localparam logic [6:0]    MMAX    = 7'(MIN_MAX);

  state_e        state_q;
  logic          mode_lvl_q;
  logic          mode_prv_q;
  logic [6:0]    hr_q;
  logic [6:0]    min_q;
  logic          load_q;
  logic          run_en_q;
  logic          phase_q;
  logic [BW-1:0] blink_q;
  logic [TW-1:0] idle_q;

  logic       mode_press;
  logic       inc_lvl, inc_press, inc_step;
  logic       dec_lvl, dec_press, dec_step;
  logic       both;
  logic       step;
  logic       activity;
  logic       to_hit;
  logic [6:0] hr_d;
  logic [6:0] min_d;

  assign mode_press = mode_lvl_q & ~mode_prv_q;
  assign both       = inc_lvl & dec_lvl;

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_RATE(REPEAT_RATE)
  ) u_inc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (inc_btn_i),
    .clr_i  (both),
    .lvl_o  (inc_lvl),
    .press_o(inc_press),
    .step_o (inc_step)
  );

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_RATE(REPEAT_RATE)
  ) u_dec (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (dec_btn_i),
    .clr_i  (both),
    .lvl_o  (dec_lvl),
    .press_o(dec_press),
    .step_o (dec_step)
  );

  assign step     = inc_step | dec_step;
  assign activity = step | inc_press | dec_press;
  assign to_hit   = (TIMEOUT != 0) && (idle_q == TO_LAST)
                    && !activity;

  always_comb begin
    hr_d  = inc_step ? wrap_inc(hr_q, HMAX)
                     : wrap_dec(hr_q, HMAX);
    min_d = inc_step ? wrap_inc(min_q, MMAX)
                     : wrap_dec(min_q, MMAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      mode_lvl_q <= 1'b0;
      mode_prv_q <= 1'b0;
      hr_q       <= '0;
      min_q      <= '0;
      load_q     <= 1'b0;
      run_en_q   <= 1'b1;
      phase_q    <= 1'b0;
      blink_q    <= '0;
      idle_q     <= '0;
    end else begin
      mode_lvl_q <= mode_btn_i;
      mode_prv_q <= mode_lvl_q;
      load_q     <= 1'b0;
      if (blink_q == BL_LAST) begin
        blink_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        blink_q <= blink_q + BW'(1);
      end
      unique case (state_q)
        RUN: begin
          idle_q   <= '0;
          run_en_q <= 1'b1;
          if (mode_press) begin
            state_q  <= SET_HR;
            run_en_q <= 1'b0;
            hr_q     <= (hours_i > HMAX) ? HMAX : hours_i;
            min_q    <= (minutes_i > MMAX) ? MMAX : minutes_i;
            blink_q  <= '0;
            phase_q  <= 1'b0;
          end
        end
        SET_HR, SET_MIN: begin
          // mode wins over a coincident inc/dec step
          if (mode_press) begin
            idle_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            if (state_q == SET_HR) begin
              state_q <= SET_MIN;
            end else begin
              state_q <= COMMIT;
              load_q  <= 1'b1;
            end
          end else if (to_hit) begin
            state_q  <= RUN;
            run_en_q <= 1'b1;
            idle_q   <= '0;
          end else begin
            idle_q <= activity ? '0 : idle_q + TW'(1);
            if (step) begin
              blink_q <= '0;
              phase_q <= 1'b0;
              if (state_q == SET_HR) hr_q <= hr_d;
              else                   min_q <= min_d;
            end
          end
        end
        COMMIT: begin
          state_q  <= RUN;
          run_en_q <= 1'b1;
        end
      endcase
    end
  end

  assign set_hour_o  = hr_q;
  assign set_min_o   = min_q;
  assign load_o      = load_q;
  assign run_en_o    = run_en_q;
  assign blank_hr_o  = phase_q & (state_q == SET_HR);
  assign blank_min_o = phase_q & (state_q == SET_MIN);
  assign state_o     = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with short blink/repeat/timeout.
// Expectations are queued with stimulus and drained after the DUT settles.
module tb_clock_set_ctrl;

  localparam int HRM = 11;
  localparam int MNM = 59;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, inc, dec;
  logic [6:0] hours, minutes;
  logic [6:0] set_hour, set_min;
  logic       load, run_en, bhr, bmin;
  logic [1:0] state;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .HR_MAX     (HRM),
    .MIN_MAX    (MNM),
    .BLINK_DIV  (3),
    .REPEAT_DLY (8),
    .REPEAT_RATE(3),
    .TIMEOUT    (20)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mode_btn_i (mode),
    .inc_btn_i  (inc),
    .dec_btn_i  (dec),
    .hours_i    (hours),
    .minutes_i  (minutes),
    .set_hour_o (set_hour),
    .set_min_o  (set_min),
    .load_o     (load),
    .run_en_o   (run_en),
    .blank_hr_o (bhr),
    .blank_min_o(bmin),
    .state_o    (state)
  );

  typedef enum int {
    K_STATE, K_HR, K_MIN, K_LOAD, K_RUN, K_BHR, K_BMIN
  } kind_e;
  typedef struct { kind_e k; int v; } exp_t;
  typedef struct { int hr; int mn; } ld_t;

  exp_t sb[$];
  ld_t  ldq[$];
  ld_t  ld_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_st, m_hr, m_mn;

  task automatic check(input string tag, input int act,
                       input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int obs(input kind_e k);
    case (k)
      K_STATE: return int'(state);
      K_HR:    return int'(set_hour);
      K_MIN:   return int'(set_min);
      K_LOAD:  return int'(load);
      K_RUN:   return int'(run_en);
      K_BHR:   return int'(bhr);
      default: return int'(bmin);
    endcase
  endfunction

  task automatic want(input kind_e k, input int v);
    exp_t e;
    e.k = k;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.k.name(), obs(e.k), e.v);
    end
  endtask

  task automatic want_model();
    want(K_STATE, m_st);
    want(K_HR, m_hr);
    want(K_MIN, m_mn);
  endtask

  task automatic want_reset();
    want_model();
    want(K_LOAD, 0);
    want(K_RUN, 1);
    want(K_BHR, 0);
    want(K_BMIN, 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int m_inc(input int v, input int mx);
    return (v + 1) % (mx + 1);
  endfunction

  function automatic int m_dec(input int v, input int mx);
    return (v + mx) % (mx + 1);
  endfunction

  task automatic press_mode();
    mode = 1'b1;
    tick(1);
    mode = 1'b0;
    tick(1);
    case (m_st)
      0: begin
        m_st = 1;
        m_hr = (hours > HRM) ? HRM : int'(hours);
        m_mn = (minutes > MNM) ? MNM : int'(minutes);
      end
      1: m_st = 2;
      2: begin
        ld_t l;
        l.hr = m_hr;
        l.mn = m_mn;
        ldq.push_back(l);
        m_st = 3;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic press_step(input bit up);
    if (up) inc = 1'b1;
    else    dec = 1'b1;
    tick(1);
    inc = 1'b0;
    dec = 1'b0;
    tick(1);
    if (m_st == 1)
      m_hr = up ? m_inc(m_hr, HRM) : m_dec(m_hr, HRM);
    else if (m_st == 2)
      m_mn = up ? m_inc(m_mn, MNM) : m_dec(m_mn, MNM);
  endtask

  // load scoreboard: every strobe cycle must match a queued commit
  always @(negedge clk) begin
    if (rst === 1'b0 && load === 1'b1) begin
      if (ldq.size() == 0) begin
        check("load_unexp", 1, 0);
      end else begin
        ld_e = ldq.pop_front();
        check("load_hr", int'(set_hour), ld_e.hr);
        check("load_min", int'(set_min), ld_e.mn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    rst = 1'b1;
    mode = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    hours = 7'd0;
    minutes = 7'd0;
    m_st = 0;
    m_hr = 0;
    m_mn = 0;
    tick(3);
    rst = 1'b0;
    want_reset();
    drain();

    hours = 7'd5;
    minutes = 7'd30;
    press_mode();
    want_model();
    want(K_RUN, 0);
    drain();

    repeat (6) press_step(1'b1);
    want(K_HR, 11);
    drain();
    press_step(1'b1);
    want(K_HR, 0);
    drain();
    press_step(1'b0);
    want(K_HR, 11);
    drain();

    press_mode();
    want(K_STATE, 2);
    want(K_MIN, 30);
    drain();
    repeat (30) press_step(1'b1);
    want(K_MIN, 0);
    drain();
    press_step(1'b0);
    want(K_MIN, 59);
    drain();
    press_mode();
    want(K_STATE, 3);
    want(K_LOAD, 1);
    want(K_RUN, 0);
    drain();
    tick(1);
    m_st = 0;
    want(K_STATE, 0);
    want(K_LOAD, 0);
    want(K_RUN, 1);
    drain();

    press_mode();
    press_step(1'b1);
    press_step(1'b1);
    press_mode();
    press_step(1'b1);
    press_mode();
    want(K_HR, 7);
    want(K_MIN, 31);
    want(K_LOAD, 1);
    want(K_STATE, 3);
    drain();
    tick(1);
    m_st = 0;
    want(K_STATE, 0);
    want(K_LOAD, 0);
    want(K_RUN, 1);
    drain();

    minutes = 7'd10;
    press_mode();
    press_mode();
    want_model();
    drain();
    inc = 1'b1;
    tick(2);
    last = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 0 || (c >= 8 && (c - 8) % 4 == 0)) begin
        m_mn = m_inc(m_mn, MNM);
        last = c;
      end
      want(K_MIN, m_mn);
      want(K_BMIN, ((c - last) / 4) % 2);
      want(K_BHR, 0);
      drain();
      if (c < 20) tick(1);
    end
    inc = 1'b0;
    tick(3);
    want(K_MIN, 15);
    drain();

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_st = 0;
    m_hr = 0;
    m_mn = 0;
    want_reset();
    drain();

    hours = 7'd3;
    minutes = 7'd4;
    press_mode();
    want_model();
    want(K_BHR, 0);
    drain();
    tick(4);
    want(K_BHR, 1);
    want(K_BMIN, 0);
    drain();
    tick(11);
    want(K_STATE, 1);
    drain();
    n = 0;
    while (state != 2'd0 && n < 10) begin
      tick(1);
      n++;
    end
    m_st = 0;
    check("timeout_state", int'(state), 0);
    check("timeout_cycles", 15 + n, 20);
    check("timeout_run", int'(run_en), 1);

    hours = 7'd14;
    minutes = 7'd75;
    press_mode();
    want(K_HR, 11);
    want(K_MIN, 59);
    drain();
    mode = 1'b1;
    inc = 1'b1;
    tick(1);
    mode = 1'b0;
    inc = 1'b0;
    tick(1);
    m_st = 2;
    want(K_STATE, 2);
    want(K_HR, 11);
    drain();
    inc = 1'b1;
    dec = 1'b1;
    tick(12);
    inc = 1'b0;
    dec = 1'b0;
    tick(2);
    want(K_MIN, 59);
    want(K_STATE, 2);
    drain();
    press_mode();
    want(K_LOAD, 1);
    drain();
    tick(1);
    want(K_STATE, 0);
    want(K_LOAD, 0);
    drain();

    tick(3);
    check("load_pending", ldq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
